// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: arbitrates collision/direction requests into timed tones with a silent gap.
// Define SOUND_SCHED_PREEMPT_EN to let a bad-collision edge cut short a good or dir tone.
module sound_event_scheduler #(
  parameter logic [23:0] TONE_CYCLES = 24'd1_500_000,
  parameter logic [23:0] GAP_CYCLES  = 24'd120_000,
  parameter logic [7:0]  GOOD_FREQ   = 8'd60,
  parameter logic [7:0]  BAD_FREQ    = 8'd200,
  parameter logic [7:0]  DIR_FREQ    = 8'd120
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  output logic       playSound,
  output logic [7:0] freq_o,
  output logic [2:0] grant_o,
  output logic       busy_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  logic [1:0]  coll_q, coll_d, coll_dly_q, coll_dly_d;
  logic [3:0]  dir_q, dir_d, dir_dly_q, dir_dly_d;
  logic [2:0]  pend_q, pend_d;
  logic [1:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        play_q, play_d;
  logic [7:0]  freq_q, freq_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  rise, pick, clr, cons;
  // Source vectors are ordered {bad, good, dir}, matching grant_o.
  always_comb begin
    coll_d     = {badColl_i, goodColl_i};
    coll_dly_d = coll_q;
    dir_d      = direction_i;
    dir_dly_d  = dir_q;
    rise       = {coll_q & ~coll_dly_q, (|dir_q) && (dir_q != dir_dly_q)};
    pick       = pend_q[2] ? 3'b100 : pend_q[1] ? 3'b010 : pend_q[0] ? 3'b001 : 3'b000;
    clr        = 3'b000;
    cons       = 3'b000;
    state_d    = state_q;
    cnt_d      = cnt_q;
    play_d     = play_q;
    freq_d     = freq_q;
    grant_d    = grant_q;
    if (state_q == IDLE) begin
      if (|pend_q) begin
        state_d = PLAY;
        cnt_d   = TONE_CYCLES - 24'd1;
        play_d  = 1'b1;
        grant_d = pick;
        freq_d  = pick[2] ? BAD_FREQ : pick[1] ? GOOD_FREQ : DIR_FREQ;
        clr     = pick;
      end
    end else if (state_q == PLAY) begin
`ifdef SOUND_SCHED_PREEMPT_EN
      // The preempting edge is consumed here rather than queued; the cut tone is dropped.
      if (rise[2] && !grant_q[2]) begin
        cnt_d   = TONE_CYCLES - 24'd1;
        grant_d = 3'b100;
        freq_d  = BAD_FREQ;
        clr     = 3'b100;
        cons    = 3'b100;
      end else
`endif
      if (cnt_q == 24'd0) begin
        state_d = GAP;
        cnt_d   = GAP_CYCLES - 24'd1;
        play_d  = 1'b0;
        freq_d  = 8'd0;
        grant_d = 3'b000;
      end else begin
        cnt_d = cnt_q - 24'd1;
      end
    end else begin
      state_d = (cnt_q == 24'd0) ? IDLE : state_q;
      cnt_d   = (cnt_q == 24'd0) ? cnt_q : cnt_q - 24'd1;
    end
    pend_d = (pend_q & ~clr) | (rise & ~cons);
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      coll_q     <= '0;
      coll_dly_q <= '0;
      dir_q      <= '0;
      dir_dly_q  <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      play_q     <= 1'b0;
      freq_q     <= '0;
      grant_q    <= '0;
    end else begin
      coll_q     <= coll_d;
      coll_dly_q <= coll_dly_d;
      dir_q      <= dir_d;
      dir_dly_q  <= dir_dly_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      play_q     <= play_d;
      freq_q     <= freq_d;
      grant_q    <= grant_d;
    end
  end
  assign playSound = play_q;
  assign freq_o    = freq_q;
  assign grant_o   = grant_q;
  assign busy_o    = state_q != IDLE;
endmodule
